// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller sharing one BCD-to-7-segment decoder across NUM_DIGITS digits.
// Optional build macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN enables leading-zero digit suppression.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    blank,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] active_q, active_d;
    logic              pending_q, pending_d;

    logic              slot_last_c;
    logic              frame_end_c;
    logic [NUM_DIGITS-1:0] lz_mask_c;

    assign slot_last_c = (slot_cnt_q == SLOT_LAST);
    assign frame_end_c = slot_last_c && (idx_q == IDX_LAST);

    // Slot counter and digit index advance
    always_comb begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        idx_d      = idx_q;
        if (slot_last_c) begin
            slot_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Double buffer: loads land in shadow, commit to active only at the frame boundary
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (frame_end_c) begin
            if (load) begin
                active_d  = digits_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (load) begin
            shadow_d  = digits_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            pending_q  <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Digit k>0 is suppressed while it and every higher nibble are zero
    logic zero_above_c;
    always_comb begin
        lz_mask_c    = '0;
        zero_above_c = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_above_c = zero_above_c && (active_q[4*k +: 4] == 4'd0);
            lz_mask_c[k] = zero_above_c;
        end
    end
`else
    assign lz_mask_c = '0;
`endif

    // Outputs decoded from registers only
    always_comb begin
        bcd_out    = 4'd0;
        digit_en_n = '1;
        blank      = (slot_cnt_q < BLANK_END);
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                bcd_out = active_q[4*k +: 4];
                if (!blank && !lz_mask_c[k]) begin
                    digit_en_n[k] = 1'b0;
                end
            end
        end
    end

    assign pending    = pending_q;
    assign frame_done = frame_end_c;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frame).
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en_n;
    logic        blank;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .digits_in (digits_in),
        .bcd_out   (bcd_out),
        .digit_en_n(digit_en_n),
        .blank     (blank),
        .pending   (pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Expected {bcd_out, digit_en_n, blank, frame_done} at cycle c after reset release
    function automatic logic [9:0] exp_scan(input logic [15:0] act, input int c);
        int         s;
        int         d;
        logic [3:0] e;
        logic [3:0] b;
        logic       lz;
        s  = c % 8;
        d  = (c / 8) % 4;
        b  = act[d*4 +: 4];
        e  = 4'b1111;
        if (s >= 2) e[d] = 1'b0;
        lz = (d > 0) && ((act >> (4*d)) == 16'd0);
`ifndef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        lz = 1'b0;
`endif
        if (lz) e = 4'b1111;
        return {b, e, (s < 2), ((c % 32) == 31)};
    endfunction

    task automatic do_reset;
        rst_n     = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [9:0] got;
        logic [9:0] exp;
        rst_n     = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        #3;
        if ({bcd_out, digit_en_n, blank, frame_done, pending} !== {4'h0, 4'b1111, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold got %b exp %b", {bcd_out, digit_en_n, blank, frame_done, pending},
                     {4'h0, 4'b1111, 1'b1, 1'b0, 1'b0});
        end
        checks++;
        load = 1'b1;
        digits_in = 16'hFFFF;
        @(posedge clk);
        #1;
        if ({bcd_out, digit_en_n, blank, frame_done, pending} !== {4'h0, 4'b1111, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold_load got %b exp %b", {bcd_out, digit_en_n, blank, frame_done, pending},
                     {4'h0, 4'b1111, 1'b1, 1'b0, 1'b0});
        end
        checks++;
        load = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            got = {bcd_out, digit_en_n, blank, frame_done};
            exp = exp_scan(16'h0000, c);
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_scan c=%0d got %b exp %b", c, got, exp);
            end
            checks++;
            if (pending !== 1'b0) begin
                errors++;
                $display("FAIL reset_pending c=%0d got %b exp 0", c, pending);
            end
            checks++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_basic_scan;
        logic [15:0] act;
        logic [9:0]  got;
        logic [9:0]  exp;
        logic        ep;
        do_reset;
        digits_in = 16'h4321;
        for (int c = 0; c < 64; c++) begin
            load = (c == 5);
            act  = (c >= 32) ? 16'h4321 : 16'h0000;
            ep   = (c >= 6) && (c <= 31);
            got  = {bcd_out, digit_en_n, blank, frame_done};
            exp  = exp_scan(act, c);
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_scan c=%0d got %b exp %b", c, got, exp);
            end
            checks++;
            if (pending !== ep) begin
                errors++;
                $display("FAIL basic_pending c=%0d got %b exp %b", c, pending, ep);
            end
            checks++;
            @(posedge clk);
            #1;
        end
        load = 1'b0;
    endtask

    task automatic test_overwrite;
        logic [15:0] act;
        logic [9:0]  got;
        logic [9:0]  exp;
        logic        ep;
        do_reset;
        for (int c = 0; c < 64; c++) begin
            load      = (c == 3) || (c == 20);
            digits_in = (c < 10) ? 16'h1111 : 16'h2222;
            act       = (c >= 32) ? 16'h2222 : 16'h0000;
            ep        = (c >= 4) && (c <= 31);
            got       = {bcd_out, digit_en_n, blank, frame_done};
            exp       = exp_scan(act, c);
            if (got !== exp) begin
                errors++;
                $display("FAIL overwrite_scan c=%0d got %b exp %b", c, got, exp);
            end
            checks++;
            if (pending !== ep) begin
                errors++;
                $display("FAIL overwrite_pending c=%0d got %b exp %b", c, pending, ep);
            end
            checks++;
            @(posedge clk);
            #1;
        end
        load = 1'b0;
    endtask

    task automatic test_boundary_load;
        logic [15:0] act;
        logic [9:0]  got;
        logic [9:0]  exp;
        do_reset;
        digits_in = 16'h9876;
        for (int c = 0; c < 96; c++) begin
            load = (c == 31);
            act  = (c >= 32) ? 16'h9876 : 16'h0000;
            got  = {bcd_out, digit_en_n, blank, frame_done};
            exp  = exp_scan(act, c);
            if (got !== exp) begin
                errors++;
                $display("FAIL boundary_scan c=%0d got %b exp %b", c, got, exp);
            end
            checks++;
            if (pending !== 1'b0) begin
                errors++;
                $display("FAIL boundary_pending c=%0d got %b exp 0", c, pending);
            end
            checks++;
            @(posedge clk);
            #1;
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [15:0] act;
        logic [9:0]  got;
        logic [9:0]  exp;
        logic        ep;
        do_reset;
        for (int c = 0; c < 96; c++) begin
            load      = (c == 0) || (c == 31) || (c == 40);
            digits_in = (c == 31) ? 16'h0E0D : 16'hFCBA;
            act       = (c >= 64) ? 16'hFCBA : (c >= 32) ? 16'h0E0D : 16'h0000;
            ep        = ((c >= 1) && (c <= 31)) || ((c >= 41) && (c <= 63));
            got       = {bcd_out, digit_en_n, blank, frame_done};
            exp       = exp_scan(act, c);
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_scan c=%0d got %b exp %b", c, got, exp);
            end
            checks++;
            if (pending !== ep) begin
                errors++;
                $display("FAIL b2b_pending c=%0d got %b exp %b", c, pending, ep);
            end
            checks++;
            @(posedge clk);
            #1;
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [15:0] act;
        logic [9:0]  got;
        logic [9:0]  exp;
        logic        ep;
        do_reset;
        for (int c = 0; c < 52; c++) begin
            load      = (c == 3) || (c == 40);
            digits_in = (c < 32) ? 16'h4321 : 16'h5678;
            act       = (c >= 32) ? 16'h4321 : 16'h0000;
            ep        = ((c >= 4) && (c <= 31)) || (c >= 41);
            got       = {bcd_out, digit_en_n, blank, frame_done};
            exp       = exp_scan(act, c);
            if (got !== exp) begin
                errors++;
                $display("FAIL midrst_scan c=%0d got %b exp %b", c, got, exp);
            end
            checks++;
            if (pending !== ep) begin
                errors++;
                $display("FAIL midrst_pending c=%0d got %b exp %b", c, pending, ep);
            end
            checks++;
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        // cycle 52 is slot 2, slot cycle 4, with new data pending
        if ({bcd_out, digit_en_n, blank, pending} !== {4'h3, 4'b1011, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midrst_before got %b exp %b", {bcd_out, digit_en_n, blank, pending},
                     {4'h3, 4'b1011, 1'b0, 1'b1});
        end
        checks++;
        rst_n = 1'b0;
        #1;
        if ({bcd_out, digit_en_n, blank, frame_done, pending} !== {4'h0, 4'b1111, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_async got %b exp %b", {bcd_out, digit_en_n, blank, frame_done, pending},
                     {4'h0, 4'b1111, 1'b1, 1'b0, 1'b0});
        end
        checks++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 64; c++) begin
            got = {bcd_out, digit_en_n, blank, frame_done};
            exp = exp_scan(16'h0000, c);
            if (got !== exp) begin
                errors++;
                $display("FAIL midrst_after c=%0d got %b exp %b", c, got, exp);
            end
            checks++;
            if (pending !== 1'b0) begin
                errors++;
                $display("FAIL midrst_after_pending c=%0d got %b exp 0", c, pending);
            end
            checks++;
            @(posedge clk);
            #1;
        end
    endtask

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    task automatic test_lz_blank;
        logic [15:0] act;
        logic [9:0]  got;
        logic [9:0]  exp;
        do_reset;
        for (int c = 0; c < 96; c++) begin
            load      = (c == 0) || (c == 40);
            digits_in = (c < 32) ? 16'h0070 : 16'h0000;
            act       = (c >= 32 && c < 64) ? 16'h0070 : 16'h0000;
            got       = {bcd_out, digit_en_n, blank, frame_done};
            exp       = exp_scan(act, c);
            if (got !== exp) begin
                errors++;
                $display("FAIL lz_scan c=%0d got %b exp %b", c, got, exp);
            end
            checks++;
            if ((c >= 32 && c < 64 && digit_en_n[3:2] !== 2'b11) ||
                (c >= 64 && digit_en_n[3:1] !== 3'b111)) begin
                errors++;
                $display("FAIL lz_suppress c=%0d got %b", c, digit_en_n);
            end
            checks++;
            @(posedge clk);
            #1;
        end
        load = 1'b0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        test_reset;
        test_basic_scan;
        test_overwrite;
        test_boundary_load;
        test_back_to_back;
        test_reset_mid;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        test_lz_blank;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one active-low BCD-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Each cycle it presents one digit's BCD nibble to the decoder's A..D inputs (A = MSB) and drives that digit's active-low enable.
- A blanking gap at the start of every slot suppresses ghosting.
- New display values are double-buffered and committed only at frame boundaries, so no tearing.

Parameters:
NUM_DIGITS, 4, digits scanned (1..8).
REFRESH_DIV, 1000, clock cycles per digit slot (must be > BLANK_CYCLES).
BLANK_CYCLES, 2, cycles at the start of each slot with all digits disabled (must be >= 1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
load  in  1  single-cycle strobe: capture digits_in.
digits_in  in  4*NUM_DIGITS  BCD nibbles; digit k at bits [4k+3:4k], digit 0 is least significant.
bcd_out  out  4  nibble to the decoder: bcd_out[3]=A, bcd_out[0]=D.
digit_en_n  out  NUM_DIGITS  active-low one-hot digit enable.
blank  out  1  high during blanking cycles.
pending  out  1  shadow holds data not yet displayed.
frame_done  out  1  one-cycle pulse on the last cycle of the last slot.

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous, active-low, and the only reset.
- Internal state: slot_cnt (0..REFRESH_DIV-1), idx (0..NUM_DIGITS-1), shadow, active (4*NUM_DIGITS each), pending.
- All outputs are registered or decoded purely from registers. There is no combinational input-to-output path.
- Reset values (asserted, or mid-operation):
  - slot_cnt=0, idx=0, active=0, shadow=0, pending=0.
  - Outputs: bcd_out=0, digit_en_n=all ones, blank=1, frame_done=0.
  - Reset mid-frame discards any pending data.
- Scan sequence:
  - slot_cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
  - blank=1 and digit_en_n=all ones while slot_cnt < BLANK_CYCLES.
  - Otherwise blank=0 and digit_en_n has only bit idx low.
  - bcd_out = active[4*idx+3:4*idx] for the whole slot, including its blanking cycles.
- Frame timing: one frame = NUM_DIGITS*REFRESH_DIV cycles. frame_done=1 exactly when idx=NUM_DIGITS-1 and slot_cnt=REFRESH_DIV-1.
- Load handling:
  - load=1 at a non-boundary cycle: shadow <= digits_in and pending <= 1 on that edge.
  - A later load in the same frame overwrites shadow (last write wins).
- Commit at frame boundary (edge where frame_done=1):
  - If load=1 on this cycle: active <= digits_in directly, pending <= 0.
  - Else if pending=1: active <= shadow, pending <= 0.
  - Else active holds.
- Display latency: first display of new data is slot 0 of the frame that follows the commit edge, after its BLANK_CYCLES.
- Nibbles 10..15 pass through unmodified. The decoder defines their glyphs.
- Latency:
  - load to pending high: 1 cycle.
  - load to display: worst case one frame plus BLANK_CYCLES.

Optional Feature:
SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: leading-zero suppression is on.
  - Any digit k > 0 whose nibble and all higher nibbles in active are 0 keeps digit_en_n[k]=1 for its whole slot, including non-blank cycles.
  - blank still follows slot_cnt only.
  - Digit 0 is never suppressed.
  - Scan timing is unchanged.
- Undefined: every digit is enabled in its slot as described above.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, giving a 32-cycle frame.
1. Reset: hold rst_n=0 -> digit_en_n=4'b1111, blank=1, bcd_out=0, pending=0, frame_done=0. Release -> frame_done first pulses at cycle 31.
2. Basic scan: load 16'h4321 at cycle 5 -> pending=1 from cycle 6 until the commit edge at cycle 31. Next frame shows:
   - slot0: bcd_out=1, digit_en_n=4'b1110 on slot cycles 2..7, 4'b1111 on cycles 0..1.
   - slot1: bcd_out=2, digit_en_n=4'b1101.
   - slot2: bcd_out=3, digit_en_n=4'b1011.
   - slot3: bcd_out=4, digit_en_n=4'b0111.
3. Overwrite: load 16'h1111 at cycle 3, then 16'h2222 at cycle 20 -> the next frame shows 2 on every digit; 1 is never displayed.
4. Boundary load: load 16'h9876 coincident with frame_done -> active=16'h9876 at that edge, pending stays 0, and the next frame shows 6,7,8,9 in slots 0..3.
5. Reset mid-operation: rst_n=0 at slot 2 cycle 4 with pending=1 -> outputs return immediately to reset values. After release, active=0, so bcd_out=0 in all slots and pending=0.
6. SEVEN_SEG_LEADING_ZERO_BLANK_EN defined:
   - load 16'h0070 -> digits 3 and 2 never enabled; digit1 shows 7, digit0 shows 0.
   - load 16'h0000 -> only digit_en_n[0] ever goes low.
